// File: rtl/a1339_spi_responder.sv
// A1339 angle-sensor SPI slave emulator (mode 1, 16-bit frames, responses pipelined by one frame).
// Define A1339_RESP_PARITY_EN to replace response bit 12 with odd parity over the other 15 bits.
module a1339_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  ANGLE_ADDR  = 7'h20,
  parameter logic [6:0]  STATUS_ADDR = 7'h24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [11:0] angle_i,
  input  logic        new_sample_i,
  output logic [11:0] zero_offset_o,
  output logic [15:0] frame_count_o,
  output logic        error_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone, StAbort} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [15:0]            shift_out_q, shift_out_d;
  logic [15:0]            shift_in_q, shift_in_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic                   miso_q, miso_d;
  logic [15:0]            pending_q, pending_d;
  logic [11:0]            offset_q, offset_d;
  logic [11:0]            angle_snap_q, angle_snap_d;
  logic                   new_q, new_d;
  logic                   err_q, err_d;
  logic [15:0]            count_q, count_d;

  logic        sck_s, ss_s, mosi_s;
  logic        sck_rise, sck_fall, ss_fall, ss_rise;
  logic [15:0] load_word;
  logic [11:0] rel_angle;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_data;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;

  assign rel_angle = angle_snap_q - offset_q;
  assign cmd_addr  = shift_in_q[14:8];
  assign cmd_data  = shift_in_q[7:0];

`ifdef A1339_RESP_PARITY_EN
  assign load_word = {pending_q[15:13], ~^{pending_q[15:13], pending_q[11:0]}, pending_q[11:0]};
`else
  assign load_word = pending_q;
`endif

  always_comb begin
    state_d      = state_q;
    shift_out_d  = shift_out_q;
    shift_in_d   = shift_in_q;
    bit_cnt_d    = bit_cnt_q;
    miso_d       = miso_q;
    pending_d    = pending_q;
    offset_d     = offset_q;
    angle_snap_d = angle_snap_q;
    new_d        = new_q;
    err_d        = err_q;
    count_d      = count_q;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (ss_fall) state_d = StLoad;
      end
      StLoad: begin
        shift_out_d  = load_word;
        miso_d       = load_word[15];
        bit_cnt_d    = 5'd0;
        shift_in_d   = 16'h0000;
        angle_snap_d = angle_i;
        state_d      = StShift;
      end
      StShift: begin
        if (ss_rise) begin
          state_d = (bit_cnt_q == 5'd16) ? StDone : StAbort;
        end else begin
          // Bit 15 is already on miso from LOAD, so the first rise only opens the frame.
          if (sck_rise && bit_cnt_q != 5'd0 && bit_cnt_q < 5'd16) begin
            shift_out_d = {shift_out_q[14:0], 1'b0};
            miso_d      = shift_out_q[14];
          end
          if (sck_fall && bit_cnt_q < 5'd16) begin
            shift_in_d = {shift_in_q[14:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 5'd1;
          end
        end
      end
      StDone: begin
        miso_d  = 1'b0;
        count_d = count_q + 16'd1;
        state_d = StIdle;
        if (shift_in_q[15]) begin
          if (cmd_addr == 7'h06) offset_d[7:0] = cmd_data;
          else if (cmd_addr == 7'h07) offset_d[11:8] = cmd_data[3:0];
          pending_d = 16'h0001;
        end else if (cmd_addr == ANGLE_ADDR) begin
          pending_d = {err_q, new_q, 2'b00, rel_angle};
          new_d     = 1'b0;
          err_d     = 1'b0;
        end else if (cmd_addr == STATUS_ADDR) begin
          pending_d = {err_q, new_q, 2'b00, count_q[11:0]};
        end else begin
          pending_d = 16'h8000;
        end
      end
      StAbort: begin
        miso_d  = 1'b0;
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A fresh sample always wins over a clear in the same cycle.
    if (new_sample_i) new_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      // ss_n sync resets low so a select held through reset cannot look like a frame start.
      sck_sync_q   <= '0;
      ss_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sck_prev_q   <= 1'b0;
      ss_prev_q    <= 1'b0;
      shift_out_q  <= 16'h0000;
      shift_in_q   <= 16'h0000;
      bit_cnt_q    <= 5'd0;
      miso_q       <= 1'b0;
      pending_q    <= 16'h0000;
      offset_q     <= 12'h000;
      angle_snap_q <= 12'h000;
      new_q        <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q   <= sck_s;
      ss_prev_q    <= ss_s;
      shift_out_q  <= shift_out_d;
      shift_in_q   <= shift_in_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_q       <= miso_d;
      pending_q    <= pending_d;
      offset_q     <= offset_d;
      angle_snap_q <= angle_snap_d;
      new_q        <= new_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = (state_q == StLoad) || (state_q == StShift);
  assign zero_offset_o = offset_q;
  assign frame_count_o = count_q;
  assign error_o       = err_q;

endmodule
